pipe_narrow: RTL
================

PIPE_NARROW -- requirements
Module: pipe_narrow

Interface
- REQ-001: Parameter WIDE, default 32, SHALL set the source word width in bits.
- REQ-002: Parameter NARROW, default 8, SHALL set the sink beat width in bits; WIDE SHALL be an integer multiple of NARROW, and RATIO = WIDE/NARROW SHALL be >= 2.
- REQ-003: Port CLK, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-004: Port RST, input, 1, SHALL be the synchronous, active-high reset.
- REQ-005: Port src, PipeOut.client, SHALL consume wide words: deq__ENA output 1, deq__RDY input 1, first input WIDE, first__RDY input 1.
- REQ-006: Port snk, PipeIn.client, SHALL produce narrow beats: enq__ENA output 1, enq$v output NARROW, enq__RDY input 1.

Function
- REQ-007: The block SHALL be a two-state FSM, IDLE (no word held) and BUSY (word held, beats pending).
- REQ-008: src.deq__ENA SHALL be asserted only when src.deq__RDY && src.first__RDY && (state==IDLE || last-beat-accepted this cycle).
- REQ-009: On src.deq__ENA, the block SHALL capture src.first into a WIDE-bit shift buffer, clear beat counter cnt to 0, and enter or stay in BUSY.
- REQ-010: In BUSY, snk.enq$v SHALL equal buf[NARROW-1:0]; in IDLE, snk.enq$v SHALL be 0.
- REQ-011: snk.enq__ENA SHALL equal (state==BUSY) && snk.enq__RDY, and SHALL never be asserted while enq__RDY is low.
- REQ-012: On an accepted beat with cnt < RATIO-1, buf SHALL shift right by NARROW (zero fill) and cnt SHALL increment.
- REQ-013: On an accepted beat with cnt == RATIO-1, the block SHALL reload from src in the same cycle if REQ-008 allows, else return to IDLE.
- REQ-014: Latency SHALL be 1 cycle from src.deq__ENA to the first beat being valid on snk; sustained throughput SHALL be one beat per cycle with no bubble between words.
- REQ-015: cnt SHALL be ceil(log2(RATIO)) bits wide and SHALL never exceed RATIO-1.
- REQ-016: While snk.enq__RDY is low, buf, cnt and state SHALL hold and src.deq__ENA SHALL be low.
- REQ-017: src.deq__ENA and snk.enq__ENA SHALL be purely combinational from state and inputs, with no combinational path from src.first to any ENA.

Reset
- REQ-018: While RST is high at a CLK edge, state SHALL become IDLE, and buf and cnt SHALL become 0.
- REQ-019: While RST is high, src.deq__ENA and snk.enq__ENA SHALL be 0.
- REQ-020: Reset mid-word SHALL discard the remaining beats, and no partial word SHALL resume after reset.

Configuration
- REQ-021: With PIPE_NARROW_MSB_FIRST_EN defined, beats SHALL issue most-significant first: snk.enq$v = buf[WIDE-1:WIDE-NARROW], and buf shifts left.
- REQ-022: Without PIPE_NARROW_MSB_FIRST_EN, beats SHALL issue least-significant first per REQ-010/REQ-012.

Structure
- REQ-023: Package pipe_narrow_pkg SHALL hold the FSM state typedef (IDLE, BUSY) and a function computing cnt width from RATIO.
- REQ-024: No sub-module SHALL be used; the FSM, counter and buffer SHALL live in pipe_narrow.
- REQ-025: The block SHALL elaborate-time error if WIDE % NARROW != 0 or RATIO < 2.

Verification (WIDE=32, NARROW=8 unless stated)
- REQ-026: Single word 0x44332211 with snk always ready -> beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, then IDLE.
- REQ-027: Two words 0x44332211 and 0x88776655 continuously available -> 8 beats with no gap, and the second deq__ENA coincides with beat 0x44.
- REQ-028: snk.enq__RDY low for 3 cycles after beat 0x22 -> enq__ENA is 0 for those cycles, then 0x33 and 0x44 follow; no beat is lost or duplicated.
- REQ-029: RST pulsed 1 cycle after beat 0x22 -> no further beats, state IDLE, and the next word starts at its low byte.
- REQ-030: With PIPE_NARROW_MSB_FIRST_EN defined, word 0x44332211 -> beats 0x44, 0x33, 0x22, 0x11.
- REQ-031: With WIDE=16, NARROW=4 and random ready/valid over 1000 words -> the reassembled stream equals the source stream.

Source files
------------

// File: rtl/pipe_narrow_pkg.sv
// Shared types and helpers for the wide-to-narrow beat splitter.
package pipe_narrow_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat counter width; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/pipe_narrow_if.sv
// Pipe handshake bundles: PipeOut is a dequeue-side source, PipeIn an enqueue-side sink.
interface PipeOut #(parameter int unsigned WIDTH = 32);
    logic             deq__ENA;
    logic             deq__RDY;
    logic [WIDTH-1:0] first;
    logic             first__RDY;

    modport client (output deq__ENA, input deq__RDY, input first, input first__RDY);
    modport server (input deq__ENA, output deq__RDY, output first, output first__RDY);
endinterface

interface PipeIn #(parameter int unsigned WIDTH = 8);
    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;

    modport client (output enq__ENA, output enq_v, input enq__RDY);
    modport server (input enq__ENA, input enq_v, output enq__RDY);
endinterface

// File: rtl/pipe_narrow.sv
// Splits each WIDE-bit source word into WIDE/NARROW beats, one per cycle.
// Define PIPE_NARROW_MSB_FIRST_EN to issue the most-significant beat first.
module pipe_narrow
    import pipe_narrow_pkg::*;
#(
    parameter int unsigned WIDE   = 32,
    parameter int unsigned NARROW = 8
) (
    input  logic   CLK,
    input  logic   RST,
    PipeOut.client src,
    PipeIn.client  snk
);

    localparam int unsigned RATIO = WIDE / NARROW;
    localparam int unsigned CW    = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    if (((WIDE % NARROW) != 0) || (RATIO < 2)) begin : g_bad_cfg
        $error("pipe_narrow: WIDE must be a multiple of NARROW with WIDE/NARROW >= 2");
    end

    state_t          state;
    logic [WIDE-1:0] shift_q;
    logic [CW-1:0]   cnt;

    logic              beat_c;
    logic              last_beat_c;
    logic              load_c;
    logic [NARROW-1:0] beat_data_c;
    logic [WIDE-1:0]   shift_next_c;

    // Handshake decode: a stalled sink freezes everything, including loads from IDLE.
    always_comb begin
        beat_c      = 1'b0;
        last_beat_c = 1'b0;
        load_c      = 1'b0;
        if (!RST && snk.enq__RDY) begin
            beat_c      = (state == BUSY);
            last_beat_c = beat_c && (cnt == LAST_CNT);
            load_c      = src.deq__RDY && src.first__RDY &&
                          ((state == IDLE) || last_beat_c);
        end
    end

`ifdef PIPE_NARROW_MSB_FIRST_EN
    assign beat_data_c  = shift_q[WIDE-1 -: NARROW];
    assign shift_next_c = shift_q << NARROW;
`else
    assign beat_data_c  = shift_q[NARROW-1:0];
    assign shift_next_c = shift_q >> NARROW;
`endif

    assign src.deq__ENA = load_c;
    assign snk.enq__ENA = beat_c;
    assign snk.enq_v    = (state == BUSY) ? beat_data_c : '0;

    // A reload on the last beat takes priority so words stream back to back.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt     <= '0;
        end else if (load_c) begin
            state   <= BUSY;
            shift_q <= src.first;
            cnt     <= '0;
        end else if (last_beat_c) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt     <= '0;
        end else if (beat_c) begin
            shift_q <= shift_next_c;
            cnt     <= cnt + CW'(1);
        end
    end

endmodule
